// File: rtl/soc_pll_pkg.sv
// Shared types and helpers for the PLL lock manager.
package soc_pll_pkg;

    // FSM states; the encoding is visible on state_o.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } pll_state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL locked flag into refclk.
module soc_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    // Shift the input through two flops; both clear to 0 on reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so q_o takes the old meta_q, giving two stages.
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/soc_pll_lock_manager.sv
// PLL supervisor: pulses the PLL reset, qualifies lock, then releases channel
// resets in index order with a fixed gap; any loss or request restarts it.
module soc_pll_lock_manager
    import soc_pll_pkg::*;
#(
    parameter int NUM_CLOCKS          = 4,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int RELEASE_GAP_CYCLES  = 8,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  rst_req,
    input  logic [NUM_CLOCKS-1:0] chan_en,
    output logic                  pll_rst,
    output logic [NUM_CLOCKS-1:0] chan_rst,
    output logic                  locked_o,
    output logic [2:0]            state_o,
    output logic                  timeout_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    // One timer serves every phase, so it is sized for the longest one.
    localparam int TMR_MAX = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                  max2(LOCK_TIMEOUT_CYCLES, RELEASE_GAP_CYCLES)) - 1;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam int IDX_W   = cnt_width(NUM_CLOCKS);

    localparam logic [TMR_W-1:0]      RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]      TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]      STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]      GAP_LAST     = TMR_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_NONE     = IDX_W'(NUM_CLOCKS);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX     = '1;

    pll_state_e            state_q;
    logic [TMR_W-1:0]      tmr_q;
    logic [IDX_W-1:0]      rel_idx_q;
    logic                  pll_rst_q;
    logic [NUM_CLOCKS-1:0] chan_rst_q;
    logic                  locked_q;
    logic                  timeout_q;
    logic [LOSS_CNT_W-1:0] loss_q;

    logic                  lock_s;
    logic                  loss_ev;
    logic                  start_rel;
    logic                  gap_done;
    logic                  rel_step;
    logic [IDX_W-1:0]      cur_idx;
    logic [IDX_W-1:0]      nxt_idx;
    logic [NUM_CLOCKS-1:0] rel_mask;

    // Lowest enabled channel at index >= from, or IDX_NONE when there is none.
    function automatic logic [IDX_W-1:0] next_enabled(input logic [NUM_CLOCKS-1:0] en,
                                                      input int from);
        logic [IDX_W-1:0] idx;
        idx = IDX_NONE;
        for (int i = NUM_CLOCKS - 1; i >= 0; i--) begin
            if ((i >= from) && en[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    soc_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lock_s)
    );

    // Decode loss, release-step timing and which channel (if any) is released this edge.
    always_comb begin
        // NOTE: every signal here is assigned on all paths, so no latch is inferred.
        loss_ev   = !lock_s && ((state_q == ST_RELEASE) || (state_q == ST_RUN));
        // The WAIT_LOCK edge that first sees lock counts as the first stable sample.
        start_rel = lock_s &&
                    (((state_q == ST_WAIT_LOCK) && (LOCK_STABLE_CYCLES == 1)) ||
                     ((state_q == ST_STABLE) && (tmr_q == STABLE_LAST)));
        gap_done  = (state_q == ST_RELEASE) && (tmr_q == GAP_LAST);
        rel_step  = start_rel || gap_done;
        cur_idx   = next_enabled(chan_en, (state_q == ST_RELEASE) ? int'(rel_idx_q) : 0);
        nxt_idx   = next_enabled(chan_en, int'(cur_idx) + 1);
        rel_mask  = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (rel_step && (cur_idx == IDX_W'(i))) rel_mask[i] = 1'b1;
        end
    end

    // Sequencing FSM with its timer, release index, flags and loss counter.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= ST_RESET_PLL;
            tmr_q      <= '0;
            rel_idx_q  <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            loss_q     <= '0;
        end else begin
            // Disabled channels are forced back into reset whatever the state.
            chan_rst_q <= (chan_rst_q & ~rel_mask) | ~chan_en;
            locked_q   <= 1'b0;
            if (loss_ev) begin
                // A coincident rst_req is absorbed here, so the loss is counted once.
                state_q    <= ST_RESET_PLL;
                tmr_q      <= '0;
                pll_rst_q  <= 1'b1;
                chan_rst_q <= '1;
                if (loss_q != LOSS_MAX) loss_q <= loss_q + LOSS_CNT_W'(1);
            end else if (rst_req) begin
                state_q    <= ST_RESET_PLL;
                tmr_q      <= '0;
                pll_rst_q  <= 1'b1;
                chan_rst_q <= '1;
            end else if (rel_step) begin
                tmr_q <= '0;
                if (nxt_idx == IDX_NONE) begin
                    state_q <= ST_RUN;
                end else begin
                    state_q   <= ST_RELEASE;
                    rel_idx_q <= nxt_idx;
                end
            end else begin
                case (state_q)
                    ST_RESET_PLL: begin
                        if (tmr_q == RST_LAST) begin
                            state_q   <= ST_WAIT_LOCK;
                            tmr_q     <= '0;
                            pll_rst_q <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state_q <= ST_STABLE;
                            tmr_q   <= TMR_W'(1);
                        end else if (tmr_q == TIMEOUT_LAST) begin
                            state_q   <= ST_RESET_PLL;
                            tmr_q     <= '0;
                            pll_rst_q <= 1'b1;
                            timeout_q <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        if (!lock_s) begin
                            state_q <= ST_WAIT_LOCK;
                            tmr_q   <= '0;
                        end else begin
                            tmr_q <= tmr_q + TMR_W'(1);
                        end
                    end
                    ST_RELEASE: tmr_q <= tmr_q + TMR_W'(1);
                    ST_RUN:     locked_q <= 1'b1;
                    default: begin
                        state_q    <= ST_RESET_PLL;
                        tmr_q      <= '0;
                        pll_rst_q  <= 1'b1;
                        chan_rst_q <= '1;
                    end
                endcase
            end
        end
    end

    assign pll_rst   = pll_rst_q;
    assign chan_rst  = chan_rst_q;
    assign locked_o  = locked_q;
    assign state_o   = state_q;
    assign timeout_o = timeout_q;
    assign loss_cnt  = loss_q;

endmodule
